// File: rtl/bus_slot_arbiter_pkg.sv
// Shared widths and DMA state encoding for the PET bus slot arbiter.
package bus_slot_arbiter_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int CPU_ADDR_WIDTH = 16;
    localparam int RAM_ADDR_WIDTH = 17;

    typedef logic [2:0] dma_state_t;

    localparam dma_state_t ST_IDLE   = 3'd0;
    localparam dma_state_t ST_ADDR   = 3'd1;
    localparam dma_state_t ST_STROBE = 3'd2;
    localparam dma_state_t ST_ACK    = 3'd3;
    localparam dma_state_t ST_HOLD   = 3'd4;

endpackage

// File: rtl/bus_slot_arbiter_timer.sv
// Slot counter for one CPU cycle, with registered PHI2 / bus-enable decode.
module bus_slot_arbiter_timer #(
    parameter int CYCLE_LEN  = 64,
    parameter int PHI2_START = 32,
    parameter int BE_ON      = 30,
    parameter int CW         = $clog2(CYCLE_LEN)
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          cpu_en_i,
    input  logic          dma_go,
    output logic [CW-1:0] count_next,
    output logic          zero_next,
    output logic          cpu_clock_o,
    output logic          cpu_be_o
);

    localparam logic [CW-1:0] LAST = CW'(CYCLE_LEN - 1);
    localparam logic [CW-1:0] PHI2 = CW'(PHI2_START);
    localparam logic [CW-1:0] BE   = CW'(BE_ON);

    logic [CW-1:0] count;
    logic          cycle_en;
    logic          cycle_en_next;
    logic          advance;

    // The counter parks at 0 while the CPU is disabled, but a DMA accepted
    // there still runs a full (CPU-less) cycle.
    always_comb begin
        advance       = (count != '0) || cpu_en_i || dma_go;
        count_next    = count;
        cycle_en_next = cycle_en;
        if (advance) begin
            count_next = (count == LAST) ? '0 : count + 1'b1;
        end
        if (count == '0 && advance) begin
            cycle_en_next = cpu_en_i;
        end
        zero_next = (count_next == '0);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count       <= '0;
            cycle_en    <= 1'b0;
            cpu_clock_o <= 1'b0;
            cpu_be_o    <= 1'b0;
        end else begin
            count       <= count_next;
            cycle_en    <= cycle_en_next;
            cpu_clock_o <= cycle_en_next && (count_next >= PHI2);
            cpu_be_o    <= cycle_en_next && (count_next >= BE);
        end
    end

endmodule

// File: rtl/bus_slot_arbiter.sv
// Shares the PET system bus between the 6502 and a Wishbone DMA master,
// one DMA RAM transfer per CPU cycle in the window before PHI2.
module bus_slot_arbiter
    import bus_slot_arbiter_pkg::*;
#(
    parameter int CYCLE_LEN    = 64,
    parameter int PHI2_START   = 32,
    parameter int STROBE_START = 4,
    parameter int STROBE_END   = 23,
    parameter int BE_ON        = 30
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic                      cpu_en_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [RAM_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_stall_o,
    input  logic [DATA_WIDTH-1:0]     bus_data_i,
    output logic                      cpu_clock_o,
    output logic                      cpu_be_o,
    output logic [CPU_ADDR_WIDTH-1:0] bus_addr_o,
    output logic                      ram_a16_o,
    output logic                      bus_addr_oe_o,
    output logic [DATA_WIDTH-1:0]     bus_data_o,
    output logic                      bus_data_oe_o,
    output logic                      bus_we_n_o,
    output logic                      bus_we_n_oe_o,
    output logic                      ram_oe_n_o,
    output logic                      ram_we_n_o
);

    localparam int CW = $clog2(CYCLE_LEN);
    localparam logic [CW-1:0] C_STROBE  = CW'(STROBE_START);
    localparam logic [CW-1:0] C_ACK     = CW'(STROBE_END + 1);
    localparam logic [CW-1:0] C_RELEASE = CW'(STROBE_END + 4);

    logic [CW-1:0]             count_next;
    logic                      zero_next;
    logic                      accept;
    dma_state_t                state;
    dma_state_t                state_next;
    logic                      req_we;
    logic                      we_next;
    logic [RAM_ADDR_WIDTH-1:0] req_addr;
    logic [RAM_ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0]     req_data;
    logic [DATA_WIDTH-1:0]     data_next;
    logic                      busy;
    logic                      strobe;

    bus_slot_arbiter_timer #(
        .CYCLE_LEN (CYCLE_LEN),
        .PHI2_START(PHI2_START),
        .BE_ON     (BE_ON)
    ) slot_timer (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .cpu_en_i   (cpu_en_i),
        .dma_go     (accept),
        .count_next (count_next),
        .zero_next  (zero_next),
        .cpu_clock_o(cpu_clock_o),
        .cpu_be_o   (cpu_be_o)
    );

    // wb_stall_o is only low at count 0 in IDLE, so accept implies both.
    always_comb begin
        accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;
        we_next    = accept ? wb_we_i   : req_we;
        addr_next  = accept ? wb_addr_i : req_addr;
        data_next  = accept ? wb_dat_i  : req_data;
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_ADDR;
            ST_ADDR:   if (!wb_cyc_i) state_next = ST_IDLE;
                       else if (count_next == C_STROBE) state_next = ST_STROBE;
            ST_STROBE: if (!wb_cyc_i) state_next = ST_IDLE;
                       else if (count_next == C_ACK) state_next = ST_ACK;
            ST_ACK:    state_next = ST_HOLD;
            ST_HOLD:   if (count_next == C_RELEASE) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        busy   = (state_next != ST_IDLE);
        strobe = (state_next == ST_STROBE);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= ST_IDLE;
            req_we        <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            wb_ack_o      <= 1'b0;
            wb_stall_o    <= 1'b1;
            wb_dat_o      <= '0;
            bus_addr_o    <= '0;
            ram_a16_o     <= 1'b0;
            bus_addr_oe_o <= 1'b0;
            bus_data_o    <= '0;
            bus_data_oe_o <= 1'b0;
            bus_we_n_o    <= 1'b1;
            bus_we_n_oe_o <= 1'b0;
            ram_oe_n_o    <= 1'b1;
            ram_we_n_o    <= 1'b1;
        end else begin
            state         <= state_next;
            req_we        <= we_next;
            req_addr      <= addr_next;
            req_data      <= data_next;
            wb_ack_o      <= (state_next == ST_ACK);
            wb_stall_o    <= !(zero_next && state_next == ST_IDLE);
            // Read data is taken on the last strobe count, as the RAM is still driving.
            if (state == ST_STROBE && state_next == ST_ACK && !req_we) begin
                wb_dat_o <= bus_data_i;
            end
            bus_addr_o    <= busy ? addr_next[CPU_ADDR_WIDTH-1:0] : '0;
            ram_a16_o     <= busy && addr_next[RAM_ADDR_WIDTH-1];
            bus_addr_oe_o <= busy;
            bus_data_o    <= (busy && we_next) ? data_next : '0;
            bus_data_oe_o <= busy && we_next;
            bus_we_n_o    <= !(busy && we_next);
            bus_we_n_oe_o <= busy;
            ram_oe_n_o    <= !(strobe && !we_next);
            ram_we_n_o    <= !(strobe && we_next);
        end
    end

endmodule
